// File: rtl/mem_pkg.sv
// Shared definitions for the memory word responder: responder FSM states,
// word/byte widths, the accumulator CPU opcodes and byte-slicing helpers.
package mem_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  // Responder FSM states, in the order a complete aligned access walks them.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    HI   = 3'd2,
    LO   = 3'd3,
    RESP = 3'd4
  } state_t;

  // CPU opcodes. The opcode occupies the high byte of an instruction word,
  // so 16'h0324 is LOAD with operand 0x24.
  localparam logic [BYTE_W-1:0] OP_HALT  = 8'd0;
  localparam logic [BYTE_W-1:0] OP_ADD   = 8'd1;
  localparam logic [BYTE_W-1:0] OP_LOAD  = 8'd3;
  localparam logic [BYTE_W-1:0] OP_STORE = 8'd4;
  localparam logic [BYTE_W-1:0] OP_SKIP  = 8'd6;
  localparam logic [BYTE_W-1:0] OP_JUMP  = 8'd7;

  // High (first-stored, big-endian) byte of a word.
  function automatic logic [BYTE_W-1:0] word_hi(input logic [WORD_W-1:0] w);
    return w[WORD_W-1:BYTE_W];
  endfunction

  // Low (second-stored) byte of a word.
  function automatic logic [BYTE_W-1:0] word_lo(input logic [WORD_W-1:0] w);
    return w[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Single-port byte RAM: writes are registered on the rising edge, the read
// port shows the byte at the current address within the same cycle so the
// responder can capture it at the end of the HI/LO cycle that addresses it.
module mem_byte_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 65536
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BYTE_W-1:0] wdata,
  output logic [BYTE_W-1:0] rdata
);

  // Storage is never cleared; contents survive reset.
  logic [BYTE_W-1:0] mem_r [DEPTH];

  // Byte write on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/mem_word_responder.sv
// Memory-side responder for the accumulator CPU. Accepts one 16-bit word
// read/write at a time on a valid/ready request channel, performs it as two
// big-endian byte accesses (HI then LO) on a single-port byte RAM, and returns
// the result on a valid/ready response channel. A byte loader port shares the
// RAM port and wins over CPU requests while the responder is idle.
module mem_word_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 65536,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [BYTE_W-1:0] ld_data
);

  // Wait counter is loaded with the last count value so that WAIT lasts
  // exactly WAIT_CYCLES cycles (the counter reaching zero ends the state).
  localparam logic            HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam int              WAIT_LAST = (WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0;
  localparam logic [3:0]      WAIT_LOAD = 4'(WAIT_LAST);
  // Address of the low byte: the word address is even, so setting bit 0
  // is the same as adding one and can never carry out of the address.
  localparam logic [ADDR_W-1:0] LO_OFFSET = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_r;
  state_t              state_nxt_s;

  logic                we_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [WORD_W-1:0]   wdata_r;
  logic [3:0]          wait_cnt_r;

  logic                rsp_valid_r;
  logic [WORD_W-1:0]   rsp_rdata_r;
  logic                rsp_err_r;

  logic                accept_s;
  logic                odd_s;

  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic [BYTE_W-1:0]   mem_wdata_s;
  logic [BYTE_W-1:0]   mem_rdata_s;

  // A request is taken only in IDLE and only when the loader is not writing.
  assign accept_s  = (state_r == IDLE) && !ld_en && req_valid;
  assign odd_s     = req_addr[0];
  assign req_ready = rst && (state_r == IDLE) && !ld_en;

  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

  mem_byte_array #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .addr  (mem_addr_s),
    .wdata (mem_wdata_s),
    .rdata (mem_rdata_s)
  );

  // State register; reset returns to IDLE and drops any pending response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (odd_s) begin
            state_nxt_s = RESP;
          end else if (HAS_WAIT) begin
            state_nxt_s = WAIT;
          end else begin
            state_nxt_s = HI;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (wait_cnt_r == 4'd0) begin
          state_nxt_s = HI;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      HI: begin
        state_nxt_s = LO;
      end
      LO: begin
        state_nxt_s = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // RAM port arbitration: loader in IDLE, FSM byte accesses in HI/LO; no
  // write of any kind is issued while reset is asserted.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_s  = addr_r;
    mem_wdata_s = word_hi(wdata_r);
    if (rst) begin
      case (state_r)
        IDLE: begin
          if (ld_en) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = ld_addr;
            mem_wdata_s = ld_data;
          end else begin
            mem_we_s    = 1'b0;
            mem_addr_s  = ld_addr;
          end
        end
        HI: begin
          mem_we_s    = we_r;
          mem_addr_s  = addr_r;
          mem_wdata_s = word_hi(wdata_r);
        end
        LO: begin
          mem_we_s    = we_r;
          mem_addr_s  = addr_r | LO_OFFSET;
          mem_wdata_s = word_lo(wdata_r);
        end
        default: begin
          mem_we_s    = 1'b0;
        end
      endcase
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Request latch, wait counter and registered response fields.
  always_ff @(posedge clk) begin
    if (!rst) begin
      we_r        <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {WORD_W{1'b0}};
      wait_cnt_r  <= 4'd0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {WORD_W{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            we_r        <= req_we;
            addr_r      <= req_addr;
            wdata_r     <= req_wdata;
            wait_cnt_r  <= WAIT_LOAD;
            // Writes and errors answer with zero data, so clear it here.
            rsp_rdata_r <= {WORD_W{1'b0}};
            rsp_err_r   <= odd_s;
            // A misaligned request skips the memory and answers at once.
            rsp_valid_r <= odd_s;
          end
        end
        WAIT: begin
          if (wait_cnt_r != 4'd0) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        HI: begin
          if (!we_r) begin
            rsp_rdata_r[WORD_W-1:BYTE_W] <= mem_rdata_s;
          end
        end
        LO: begin
          if (!we_r) begin
            rsp_rdata_r[BYTE_W-1:0] <= mem_rdata_s;
          end
          rsp_valid_r <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
